csr_access_unit: RTL

//  Initiator side of the CSR file port. Takes one decoded CSR/ecall/mret instruction per

---
 rtl/csr_access_unit_if.sv | 42 ++++
 rtl/csr_access_unit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/csr_access_unit_if.sv
// Request, CSR-file and response signals of the CSR access unit, bundled as one port.
// slave is the unit's view; master is the EXU/CSR-file environment's view.
interface csr_access_unit_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      funct3;
    logic [11:0]     csr_addr_i;
    logic [4:0]      rs1_idx;
    logic [XLEN-1:0] rs1_data;
    logic [4:0]      rd_idx;
    logic [XLEN-1:0] pc;
    logic            is_ecall;
    logic            is_mret;
    logic [3:0]      csr_ctl;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] mcause_value;
    logic [XLEN-1:0] write_csr_data;
    logic [XLEN-1:0] read_csr_data;
    logic            out_valid;
    logic            out_ready;
    logic            rd_wen;
    logic [4:0]      rd_idx_o;
    logic [XLEN-1:0] rd_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    modport slave (
        input  in_valid, funct3, csr_addr_i, rs1_idx, rs1_data, rd_idx, pc,
               is_ecall, is_mret, read_csr_data, out_ready,
        output in_ready, csr_ctl, csr_addr, mcause_value, write_csr_data,
               out_valid, rd_wen, rd_idx_o, rd_data, redirect_valid, redirect_pc
    );

    modport master (
        output in_valid, funct3, csr_addr_i, rs1_idx, rs1_data, rd_idx, pc,
               is_ecall, is_mret, read_csr_data, out_ready,
        input  in_ready, csr_ctl, csr_addr, mcause_value, write_csr_data,
               out_valid, rd_wen, rd_idx_o, rd_data, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/csr_access_unit.sv
// Initiator side of the CSR file port: sequences CSRRW/S/C[I] read-modify-write,
// ecall and mret, and returns the old CSR value and the trap/return redirect PC.
module csr_access_unit #(
    parameter int XLEN        = 64,
    parameter int ECALL_CAUSE = 11
) (
    input logic            clk,
    input logic            rst,
    csr_access_unit_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_TRAP,
        S_RESP
    } state_t;

    state_t          state, state_nxt;

    logic [2:0]      funct3_q;
    logic [11:0]     addr_q;
    logic [4:0]      rs1_idx_q;
    logic [4:0]      rd_idx_q;
    logic [XLEN-1:0] rs1_data_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] old_q;
    logic [XLEN-1:0] redirect_pc_q;
    logic            ecall_q;
    logic            mret_q;
    logic            csr_op_q;
    logic            accept;
    logic            wr_suppress;
    logic [XLEN-1:0] new_val;

    logic            in_ready_c;
    logic [3:0]      csr_ctl_c;
    logic [11:0]     csr_addr_c;
    logic [XLEN-1:0] mcause_c;
    logic [XLEN-1:0] wdata_c;
    logic            out_valid_c;
    logic            rd_wen_c;
    logic            redirect_valid_c;

    // *I ops take the 5-bit zimm from the rs1 field; funct3[1:0] selects RW/RS/RC.
    function automatic logic [XLEN-1:0] csr_rmw(
        input logic [2:0]      f3,
        input logic [XLEN-1:0] old,
        input logic [4:0]      zimm,
        input logic [XLEN-1:0] rs1
    );
        logic [XLEN-1:0] src;
        src = f3[2] ? {{(XLEN-5){1'b0}}, zimm} : rs1;
        case (f3[1:0])
            2'b01:   return src;
            2'b10:   return old | src;
            2'b11:   return old & ~src;
            default: return old;
        endcase
    endfunction

    assign accept      = bus.in_valid && (state == S_IDLE);
    assign new_val     = csr_rmw(funct3_q, old_q, rs1_idx_q, rs1_data_q);
    assign wr_suppress = funct3_q[1] && (rs1_idx_q == 5'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            funct3_q      <= '0;
            addr_q        <= '0;
            rs1_idx_q     <= '0;
            rd_idx_q      <= '0;
            rs1_data_q    <= '0;
            pc_q          <= '0;
            old_q         <= '0;
            redirect_pc_q <= '0;
            ecall_q       <= 1'b0;
            mret_q        <= 1'b0;
            csr_op_q      <= 1'b0;
        end else begin
            if (accept) begin
                funct3_q      <= bus.funct3;
                addr_q        <= bus.csr_addr_i;
                rs1_idx_q     <= bus.rs1_idx;
                rd_idx_q      <= bus.rd_idx;
                rs1_data_q    <= bus.rs1_data;
                pc_q          <= bus.pc;
                old_q         <= '0;
                redirect_pc_q <= '0;
                ecall_q       <= bus.is_ecall;
                mret_q        <= !bus.is_ecall && bus.is_mret;
                csr_op_q      <= !bus.is_ecall && !bus.is_mret && (bus.funct3[1:0] != 2'b00);
            end
            // The CSR file read is combinational, so capture happens in the access cycle.
            if (state == S_READ) old_q <= bus.read_csr_data;
            if (state == S_TRAP) redirect_pc_q <= bus.read_csr_data;
        end
    end

    always_comb begin
        state_nxt        = state;
        in_ready_c       = 1'b0;
        csr_ctl_c        = 4'b0000;
        csr_addr_c       = '0;
        mcause_c         = '0;
        wdata_c          = '0;
        out_valid_c      = 1'b0;
        rd_wen_c         = 1'b0;
        redirect_valid_c = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    if (bus.is_ecall || bus.is_mret)    state_nxt = S_TRAP;
                    else if (bus.funct3[1:0] != 2'b00)  state_nxt = S_READ;
                    else                                state_nxt = S_RESP;
                end
            end
            S_READ: begin
                csr_ctl_c  = 4'b0100;
                csr_addr_c = addr_q;
                state_nxt  = S_WRITE;
            end
            S_WRITE: begin
                csr_addr_c = addr_q;
                if (!wr_suppress) begin
                    csr_ctl_c = 4'b1000;
                    wdata_c   = new_val;
                end
                state_nxt = S_RESP;
            end
            S_TRAP: begin
                if (ecall_q) begin
                    csr_ctl_c = 4'b0010;
                    wdata_c   = pc_q;
                    mcause_c  = XLEN'(ECALL_CAUSE);
                end else begin
                    csr_ctl_c = 4'b0001;
                end
                state_nxt = S_RESP;
            end
            S_RESP: begin
                out_valid_c      = 1'b1;
                rd_wen_c         = csr_op_q && (rd_idx_q != 5'd0);
                redirect_valid_c = ecall_q || mret_q;
                if (bus.out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign bus.in_ready       = in_ready_c;
    assign bus.csr_ctl        = csr_ctl_c;
    assign bus.csr_addr       = csr_addr_c;
    assign bus.mcause_value   = mcause_c;
    assign bus.write_csr_data = wdata_c;
    assign bus.out_valid      = out_valid_c;
    assign bus.rd_wen         = rd_wen_c;
    assign bus.rd_idx_o       = rd_idx_q;
    assign bus.rd_data        = old_q;
    assign bus.redirect_valid = redirect_valid_c;
    assign bus.redirect_pc    = redirect_pc_q;

endmodule
